// File: rtl/chunk_retry_pkg.sv
// Shared types for the chunked retry sequencer: FSM state encoding.
package chunk_retry_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_CKPT      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;
endpackage

// File: rtl/chunk_retry_ctrl_ckpt_counter.sv
// Beat counter with a checkpoint register; a chunk replay reloads the count from the checkpoint.
module ckpt_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i_clear,
    input  logic                i_count_en,
    input  logic                i_save,
    input  logic                i_revert,
    output logic [CNT_BITS-1:0] o_count,
    output logic [CNT_BITS-1:0] o_ckpt
);
    logic [CNT_BITS-1:0] r_count;
    logic [CNT_BITS-1:0] r_ckpt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_ckpt  <= '0;
        end else begin
            if (i_save)
                r_ckpt <= r_count;
            // clear wins over revert, revert wins over counting
            if (i_clear)
                r_count <= '0;
            else if (i_revert)
                r_count <= r_ckpt;
            else if (i_count_en)
                r_count <= r_count + CNT_BITS'(1);
        end
    end

    assign o_count = r_count;
    assign o_ckpt  = r_ckpt;
endmodule

// File: rtl/chunk_retry_ctrl.sv
// Chunked transfer sequencer: issues beats per chunk, waits for ACK/NAK, replays NAKed chunks.
module chunk_retry_ctrl
    import chunk_retry_pkg::*;
#(
    parameter int CNT_BITS   = 8,
    parameter int MAX_RETRY  = 3,
    parameter int RETRY_BITS = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_start,
    input  logic [CNT_BITS-1:0]   i_total_len,
    input  logic [CNT_BITS-1:0]   i_chunk_len,
    input  logic                  i_abort,
    input  logic                  i_beat_ready,
    input  logic                  i_resp_valid,
    input  logic                  i_resp_nak,
    output logic                  o_beat_valid,
    output logic [CNT_BITS-1:0]   o_beat_idx,
    output logic                  o_chunk_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [RETRY_BITS-1:0] o_retry_cnt
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_BITS-1:0]   r_total_len;
    logic [CNT_BITS-1:0]   r_chunk_len;
    logic [CNT_BITS-1:0]   r_chunk_cnt;
    logic [RETRY_BITS-1:0] r_retry_cnt;

    logic                  w_clear, w_save, w_revert, w_cnt_en;
    logic                  w_latch, w_chunk_clr, w_chunk_inc;
    logic                  w_retry_clr, w_retry_inc;
    logic                  w_chunk_last;
    logic [CNT_BITS-1:0]   w_beat_idx;
    logic [CNT_BITS-1:0]   w_ckpt;

    ckpt_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_ckpt_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_count_en (w_cnt_en),
        .i_save     (w_save),
        .i_revert   (w_revert),
        .o_count    (w_beat_idx),
        .o_ckpt     (w_ckpt)
    );

    // Chunk ends on its own length or on the final beat of the transfer (short last chunk)
    assign w_chunk_last = (r_state == S_SEND) &&
                          ((r_chunk_cnt == r_chunk_len - CNT_BITS'(1)) ||
                           (w_beat_idx == r_total_len - CNT_BITS'(1)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_save      = 1'b0;
        w_revert    = 1'b0;
        w_cnt_en    = 1'b0;
        w_latch     = 1'b0;
        w_chunk_clr = 1'b0;
        w_chunk_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_retry_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_latch = 1'b1;
                    if (i_total_len != '0) begin
                        w_clear     = 1'b1;
                        w_retry_clr = 1'b1;
                        w_state_nxt = S_CKPT;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_CKPT: begin
                w_save      = 1'b1;
                w_chunk_clr = 1'b1;
                w_retry_clr = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (i_beat_ready) begin
                    w_cnt_en    = 1'b1;
                    w_chunk_inc = 1'b1;
                    if (w_chunk_last)
                        w_state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (i_resp_valid) begin
                    if (!i_resp_nak) begin
                        w_state_nxt = (w_beat_idx == r_total_len) ? S_DONE : S_CKPT;
                    end else if (r_retry_cnt == RETRY_BITS'(MAX_RETRY)) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_revert    = 1'b1;
                        w_chunk_clr = 1'b1;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort overrides everything; latched lengths and counters keep their values
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b0;
            w_save      = 1'b0;
            w_revert    = 1'b0;
            w_cnt_en    = 1'b0;
            w_chunk_clr = 1'b0;
            w_chunk_inc = 1'b0;
            w_retry_clr = 1'b0;
            w_retry_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_total_len <= '0;
            r_chunk_len <= '0;
            r_chunk_cnt <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_total_len <= i_total_len;
                r_chunk_len <= (i_chunk_len == '0) ? CNT_BITS'(1) : i_chunk_len;
            end
            if (w_chunk_clr)
                r_chunk_cnt <= '0;
            else if (w_chunk_inc)
                r_chunk_cnt <= r_chunk_cnt + CNT_BITS'(1);
            if (w_retry_clr)
                r_retry_cnt <= '0;
            else if (w_retry_inc)
                r_retry_cnt <= r_retry_cnt + RETRY_BITS'(1);
        end
    end

    assign o_beat_valid = (r_state == S_SEND);
    assign o_beat_idx   = w_beat_idx;
    assign o_chunk_last = w_chunk_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_error      = (r_state == S_ERROR);
    assign o_retry_cnt  = r_retry_cnt;
endmodule

// File: tb/tb_chunk_retry_ctrl.sv
// Scoreboard bench for chunk_retry_ctrl: expected beats queued at stimulus time, popped on each transfer.
module tb_chunk_retry_ctrl;
    localparam int CNT_BITS   = 8;
    localparam int MAX_RETRY  = 3;
    localparam int RETRY_BITS = 2;

    typedef struct {
        int idx;
        int last;
        int retry;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic                  i_start;
    logic [CNT_BITS-1:0]   i_total_len;
    logic [CNT_BITS-1:0]   i_chunk_len;
    logic                  i_abort;
    logic                  i_beat_ready;
    logic                  i_resp_valid;
    logic                  i_resp_nak;
    logic                  o_beat_valid;
    logic [CNT_BITS-1:0]   o_beat_idx;
    logic                  o_chunk_last;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [RETRY_BITS-1:0] o_retry_cnt;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_xfer   = 0;
    int    n_done   = 0;
    int    n_err    = 0;
    logic  rdy_fix  = 1'b1;
    logic  rdy_mode = 1'b0;
    logic [1:0] rdy_phase = 2'd0;
    logic [3:0] rdy_pat   = 4'b1001;   // phase 0..3 -> ready 1,0,0,1
    logic  prev_stall = 1'b0;
    int    prev_idx   = 0;

    always #5 clk = ~clk;

    assign i_beat_ready = rdy_mode ? rdy_pat[rdy_phase] : rdy_fix;

    chunk_retry_ctrl #(
        .CNT_BITS   (CNT_BITS),
        .MAX_RETRY  (MAX_RETRY),
        .RETRY_BITS (RETRY_BITS)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_start      (i_start),
        .i_total_len  (i_total_len),
        .i_chunk_len  (i_chunk_len),
        .i_abort      (i_abort),
        .i_beat_ready (i_beat_ready),
        .i_resp_valid (i_resp_valid),
        .i_resp_nak   (i_resp_nak),
        .o_beat_valid (o_beat_valid),
        .o_beat_idx   (o_beat_idx),
        .o_chunk_last (o_chunk_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_retry_cnt  (o_retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rdy_mode && o_beat_valid)
            rdy_phase <= rdy_phase + 2'd1;
        else if (!rdy_mode)
            rdy_phase <= 2'd0;
    end

    // Monitor: sample between active edges
    always @(negedge clk) begin
        if (n_rst) begin
            if (o_done)  n_done++;
            if (o_error) n_err++;
            if (prev_stall && o_beat_valid)
                chk("hold_idx", 32'(o_beat_idx), 32'(prev_idx));
            if (o_beat_valid && i_beat_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(o_beat_idx), 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_idx", 32'(o_beat_idx), 32'(b.idx));
                    chk("chunk_last", 32'(o_chunk_last), 32'(b.last));
                    chk("retry_cnt", 32'(o_retry_cnt), 32'(b.retry));
                end
                n_xfer++;
            end
            prev_stall = o_beat_valid && !i_beat_ready;
            prev_idx   = int'(o_beat_idx);
        end
    end

    task automatic push_beats(input int first, input int cnt, input int retry);
        for (int k = 0; k < cnt; k++) begin
            beat_t b;
            b.idx   = first + k;
            b.last  = (k == cnt - 1) ? 1 : 0;
            b.retry = retry;
            exp_q.push_back(b);
        end
    endtask

    task automatic start_xfer(input int tot, input int ch);
        i_total_len = CNT_BITS'(tot);
        i_chunk_len = CNT_BITS'(ch);
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start     = 1'b0;
    endtask

    task automatic wait_to(input int tgt);
        int cyc = 0;
        while (n_xfer < tgt && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (n_xfer < tgt)
            chk("timeout_xfer", 32'(n_xfer), 32'(tgt));
    endtask

    task automatic respond(input logic nak);
        i_resp_valid = 1'b1;
        i_resp_nak   = nak;
        @(posedge clk); #1;
        i_resp_valid = 1'b0;
        i_resp_nak   = 1'b0;
    endtask

    initial begin
        int tgt, d0, e0;
        n_rst = 1'b0; i_start = 1'b0; i_total_len = '0; i_chunk_len = '0;
        i_abort = 1'b0; i_resp_valid = 1'b0; i_resp_nak = 1'b0;
        #12;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_beat_valid), 0);
        chk("rst_idx", 32'(o_beat_idx), 0);
        chk("rst_done_err", 32'({o_done, o_error, o_chunk_last}), 0);
        chk("rst_retry", 32'(o_retry_cnt), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // 1: 6 beats in chunks of 4, ACK each; start while busy ignored
        d0 = n_done;
        push_beats(0, 4, 0); push_beats(4, 2, 0);
        tgt = n_xfer + 4;
        start_xfer(6, 4);
        chk("lat_ckpt_valid", 32'(o_beat_valid), 0);
        @(posedge clk); #1;
        chk("lat_send_valid", 32'(o_beat_valid), 1);
        wait_to(tgt);
        chk("wait_busy", 32'({o_busy, o_beat_valid}), 32'b10);
        i_total_len = 8'd2; i_chunk_len = 8'd1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("start_busy_ign", 32'({o_busy, o_beat_valid}), 32'b10);
        respond(1'b0);
        wait_to(tgt + 2);
        respond(1'b0);
        repeat (2) @(posedge clk); #1;
        chk("t1_done", 32'(n_done - d0), 1);
        chk("t1_idle", 32'(o_busy), 0);

        // 2: one NAK then ACK
        d0 = n_done;
        push_beats(0, 4, 0);
        tgt = n_xfer + 4;
        start_xfer(4, 4);
        wait_to(tgt);
        push_beats(0, 4, 1);
        respond(1'b1);
        wait_to(tgt + 4);
        respond(1'b0);
        repeat (2) @(posedge clk); #1;
        chk("t2_done", 32'(n_done - d0), 1);

        // 3: NAK every pass -> error after MAX_RETRY replays
        d0 = n_done; e0 = n_err;
        push_beats(0, 4, 0);
        tgt = n_xfer + 4;
        start_xfer(4, 4);
        for (int r = 0; r <= MAX_RETRY; r++) begin
            wait_to(tgt);
            if (r < MAX_RETRY) push_beats(0, 4, r + 1);
            tgt += 4;
            respond(1'b1);
        end
        repeat (2) @(posedge clk); #1;
        chk("t3_err", 32'(n_err - e0), 1);
        chk("t3_no_done", 32'(n_done - d0), 0);
        chk("t3_busy", 32'(o_busy), 0);

        // 4: beat_ready pattern 1,0,0,1 while sending
        d0 = n_done;
        rdy_mode = 1'b1;
        push_beats(0, 4, 0);
        tgt = n_xfer + 4;
        start_xfer(4, 4);
        wait_to(tgt);
        respond(1'b0);
        repeat (2) @(posedge clk); #1;
        rdy_mode = 1'b0;
        chk("t4_done", 32'(n_done - d0), 1);

        // 5: abort at beat 2, then restart from beat 0
        d0 = n_done; e0 = n_err;
        push_beats(0, 2, 0);
        exp_q[1].last = 0;
        tgt = n_xfer + 2;
        start_xfer(8, 8);
        wait_to(tgt);
        rdy_fix = 1'b0;
        i_abort = 1'b1;
        chk("t5_idx_at_abort", 32'(o_beat_idx), 2);
        @(posedge clk); #1;
        i_abort = 1'b0;
        rdy_fix = 1'b1;
        chk("t5_abort_state", 32'({o_busy, o_beat_valid}), 0);
        repeat (2) @(posedge clk); #1;
        chk("t5_no_pulse", 32'((n_done - d0) + (n_err - e0)), 0);
        push_beats(0, 2, 0);
        tgt = n_xfer + 2;
        start_xfer(2, 2);
        wait_to(tgt);
        respond(1'b0);
        repeat (2) @(posedge clk); #1;
        chk("t5_restart_done", 32'(n_done - d0), 1);

        // 6: zero-length transfer and resp_valid in IDLE
        tgt = n_xfer;
        start_xfer(0, 4);
        chk("t6_done_pulse", 32'({o_done, o_beat_valid}), 32'b10);
        @(posedge clk); #1;
        chk("t6_done_once", 32'({o_done, o_busy}), 0);
        d0 = n_done;
        i_resp_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        i_resp_valid = 1'b0;
        chk("t6_resp_idle", 32'({o_busy, o_done, o_beat_valid}), 0);
        chk("t6_no_beats", 32'(n_xfer), 32'(tgt));
        chk("t6_no_done", 32'(n_done - d0), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
